// File: rtl/rf_wb_arbiter_if.sv
// Producer-side result bus into the register-file write arbiter.
// Packed per-source slices: source i occupies [i*W +: W] of each field.
interface rf_wb_arbiter_if #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;

  modport master (output src_valid, output src_addr, output src_data, input src_ready);
  modport slave  (input src_valid, input src_addr, input src_data, output src_ready);
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write side: per-source result FIFOs drained through one registered
// write port under round-robin arbitration. Writes to x0 are dropped at the input.
module rf_wb_arbiter #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_wb_arbiter_if.slave        src,
  output logic                  wEN,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [DATA_WIDTH-1:0] wData,
  output logic                  idle
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    ready;
  logic [NUM_SRC-1:0]    nonempty;
  logic [NUM_SRC-1:0]    pop;
  logic [ADDR_WIDTH-1:0] head_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0] head_data [NUM_SRC];

  logic                  grant_vld;
  logic [SW-1:0]         grant;
  logic [SW:0]           scan;
  logic [SW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push;

    // Ready comes from registered count only; a full FIFO never accepts, even on a pop.
    assign ready[gi]     = !rst && (cnt_q != CW'(FIFO_DEPTH));
    assign push          = src.src_valid[gi] && ready[gi] &&
                           (src.src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] != '0);
    assign pop[gi]       = grant_vld && (grant == SW'(gi));
    assign nonempty[gi]  = (cnt_q != '0);
    assign head_addr[gi] = mem_addr_q[rd_ptr_q];
    assign head_data[gi] = mem_data_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop[gi]) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop[gi]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_addr_q[wr_ptr_q] <= src.src_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data_q[wr_ptr_q] <= src.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign src.src_ready = ready;

  // Scan starts at rr_ptr and wraps modulo NUM_SRC; first non-empty source wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan = {1'b0, rr_ptr_q} + (SW+1)'(k);
      if (scan >= (SW+1)'(NUM_SRC)) scan = scan - (SW+1)'(NUM_SRC);
      if (!grant_vld && nonempty[scan[SW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan[SW-1:0];
      end
    end
  end

  always_comb begin
    wen_d    = grant_vld;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      waddr_d  = head_addr[grant];
      wdata_d  = head_data[grant];
      rr_ptr_d = (grant == SW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign wEN   = wen_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;
  assign idle  = (nonempty == '0) && !wen_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: producers feed per-source expected queues,
// a negedge monitor matches every RF write against the head of its source queue.
module tb_rf_wb_arbiter;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wEN;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          idle;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rf_wb_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .src   (bus),
    .wEN   (wEN),
    .wAddr (wAddr),
    .wData (wData),
    .idle  (idle)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            lat;
    int            e0;
  } beat_t;

  beat_t pend [NS][$];
  beat_t expq [NS][$];
  int    wlog_a [$];
  int    wlog_c [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    nwr     = 0;
  int    flushed = 0;
  int    acc_cnt [NS];
  bit    stall   [NS];
  bit    armed   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NS; i++) n += pend[i].size() + expq[i].size();
    return n;
  endfunction

  task tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, input int maxc);
    int c = 0;
    while ((busy_count() != 0 || idle !== 1'b1) && c < maxc) begin
      tick(1);
      c++;
    end
    chk({name, "_drain_in_time"}, 64'(c < maxc), 1);
  endtask

  // Producer driver: presents pend heads, retires a beat on valid&&ready at the edge.
  initial begin
    logic [NS-1:0] acc;
    bit            rst_edge;
    beat_t         b;
    for (int i = 0; i < NS; i++) begin
      acc_cnt[i] = 0;
      stall[i]   = 1'b0;
    end
    bus.src_valid = '0;
    bus.src_addr  = '0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk);
      acc      = bus.src_valid & bus.src_ready;
      rst_edge = rst;
      for (int i = 0; i < NS; i++)
        if (bus.src_valid[i] && !bus.src_ready[i] && !rst) stall[i] = 1'b1;
      @(posedge clk);
      #1;
      if (rst_edge) begin
        for (int i = 0; i < NS; i++) begin
          flushed += expq[i].size();
          expq[i].delete();
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          b    = pend[i].pop_front();
          b.e0 = cyc;
          acc_cnt[i]++;
          if (b.a != '0) expq[i].push_back(b);
        end
        if (pend[i].size() > 0) begin
          bus.src_valid[i]           = 1'b1;
          bus.src_addr[i*AW +: AW]   = pend[i][0].a;
          bus.src_data[i*DW +: DW]   = pend[i][0].d;
        end else begin
          bus.src_valid[i]           = 1'b0;
        end
      end
    end
  end

  // Monitor: every write must match the head of exactly one source's expected queue.
  initial begin
    int    s;
    beat_t b;
    forever begin
      @(negedge clk);
      if (armed && wEN !== 1'b0) begin
        nwr++;
        wlog_a.push_back(int'(wAddr));
        wlog_c.push_back(cyc);
        chk("wr_addr_known", 64'($isunknown(wAddr)), 0);
        chk("wr_not_x0", 64'(wAddr == '0), 0);
        s = -1;
        for (int i = 0; i < NS; i++)
          if (s < 0 && expq[i].size() > 0 && expq[i][0].a == wAddr) s = i;
        chk("wr_expected", 64'(s >= 0), 1);
        if (s >= 0) begin
          b = expq[s].pop_front();
          chk("wr_data", wData, b.d);
          if (b.lat) chk("wr_latency", 64'(cyc - b.e0), 1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n0, a0, f0, base, errs, gaps, idle_bad;
    beat_t b;
    b.lat = 1'b0;
    b.e0  = 0;

    // Reset held with all producers valid
    for (int i = 0; i < NS; i++) begin
      b.a = AW'(i + 1);
      b.d = 32'hA000_0000 + i;
      pend[i].push_back(b);
    end
    tick(1);
    armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 64'(bus.src_ready), 0);
      chk("rst_wen", 64'(wEN), 0);
      tick(1);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.src_ready), 3'b111);
    chk("post_rst_idle", 64'(idle), 1);
    chk("rst_no_accept", 64'(acc_cnt[0] + acc_cnt[1] + acc_cnt[2]), 0);
    drain("reset", 50);

    // Single beat with latency check
    n0 = nwr;
    b.a = 5'd5; b.d = 32'hDEAD_BEEF; b.lat = 1'b1;
    pend[0].push_back(b);
    b.lat = 1'b0;
    drain("single", 50);
    chk("single_one_write", 64'(nwr - n0), 1);
    chk("single_wen_low", 64'(wEN), 0);
    chk("single_idle", 64'(idle), 1);

    // Round-robin: rr_ptr sits at 1 after the single grant to src0
    base = wlog_a.size();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < NS; i++) begin
        b.a = AW'(i + 1);
        b.d = 32'h3000_0000 + 32'(k * 16 + i);
        pend[i].push_back(b);
      end
    drain("rr", 200);
    chk("rr_write_count", 64'(wlog_a.size() - base), 18);
    chk("rr_first_addr", 64'(wlog_a[base]), 2);
    errs = 0;
    gaps = 0;
    for (int k = base + 1; k < wlog_a.size(); k++) begin
      if (wlog_a[k] != (wlog_a[k-1] % 3) + 1) errs++;
      if (wlog_c[k] != wlog_c[k-1] + 1) gaps++;
    end
    chk("rr_order_errors", 64'(errs), 0);
    chk("rr_gap_cycles", 64'(gaps), 0);

    // Backpressure on src1 while src0/src2 saturate
    stall[1] = 1'b0;
    a0 = acc_cnt[1];
    for (int k = 0; k < 8; k++) begin
      b.a = 5'd4; b.d = 32'h4000_0000 + k; pend[0].push_back(b);
      b.a = 5'd6; b.d = 32'h6000_0000 + k; pend[2].push_back(b);
    end
    for (int k = 0; k < 4; k++) begin
      b.a = AW'(5 + 3 * k);
      b.d = 32'h5000_0000 + k;
      pend[1].push_back(b);
    end
    drain("bp", 300);
    chk("bp_src1_stalled", 64'(stall[1]), 1);
    chk("bp_src1_accepted", 64'(acc_cnt[1] - a0), 4);

    // x0 destination: accepted, never written
    a0 = acc_cnt[2];
    n0 = nwr;
    idle_bad = 0;
    b.a = '0; b.d = 32'h0000_1234;
    pend[2].push_back(b);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (idle !== 1'b1) idle_bad++;
    end
    chk("x0_accepted", 64'(acc_cnt[2] - a0), 1);
    chk("x0_no_write", 64'(nwr - n0), 0);
    chk("x0_idle_drops", 64'(idle_bad), 0);

    // Reset while beats are buffered
    for (int i = 0; i < NS; i++) begin
      b.a = AW'(7 + i);  b.d = 32'h7000_0000 + i; pend[i].push_back(b);
      b.a = AW'(10 + i); b.d = 32'h8000_0000 + i; pend[i].push_back(b);
    end
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < NS; i++) pend[i].delete();
    f0 = flushed;
    n0 = nwr;
    tick(1);
    chk("midrst_wen", 64'(wEN), 0);
    chk("midrst_had_buffered", 64'(flushed - f0 > 0), 1);
    rst = 1'b0;
    tick(10);
    chk("midrst_no_write", 64'(nwr - n0), 0);
    chk("midrst_idle", 64'(idle), 1);
    chk("midrst_ready", 64'(bus.src_ready), 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
